fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer in front of the byte-addressed, little-endian instruction memory (32-bit word read at addr..addr+3).
- Owns the PC, issues word fetches over a req/gnt + rvalid protocol, and buffers returned words in a small in-order queue.
- Delivers {pc, instruction} to decode over a valid/ready handshake.
- Handles redirects (branch/jump/trap) by flushing and discarding in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 61 ++++++
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned INSN_W     = 32;
  localparam int unsigned PC_W       = 32;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous DEPTH-entry FIFO with flush; the head is read straight from storage.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic          head_valid,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full queue is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_valid = (count != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues word fetches, buffers
// returned words in order and hands {pc, inst} to decode; redirects flush.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int unsigned      DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic              inst_valid,
  output logic [INSN_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned     CW         = $clog2(DEPTH + 1);
  localparam int unsigned     EW         = $bits(fetch_entry_t);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSN_BYTES - 1);

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   count;
  logic [CW-1:0]   tag_count;
  logic            pend;
  logic [CW:0]     used;
  logic            gnt_fire;
  logic            rv_fire;
  logic            drop;
  logic            dq_push;
  logic            dq_pop;
  logic            tag_valid;
  logic [XLEN-1:0] tag_pc;
  logic [EW-1:0]   dq_head;
  fetch_entry_t    push_ent;
  fetch_entry_t    head_ent;

  // Credit counts both buffered words and owed responses (discards included).
  assign used     = (CW+1)'(count) + (CW+1)'(outstanding);
  assign mem_req  = !redirect_valid && (used < (CW+1)'(DEPTH)) &&
                    (pend || ((state == S_RUN) && fetch_en));
  assign mem_addr = fetch_pc;

  assign gnt_fire = mem_req && mem_gnt;
  assign rv_fire  = mem_rvalid && (outstanding != '0);
  assign drop     = (discard != '0);
  assign dq_push  = rv_fire && !drop && !redirect_valid;
  assign dq_pop   = inst_valid && inst_ready && !redirect_valid;

  assign push_ent  = '{pc: PC_W'(tag_pc), inst: mem_rdata};
  assign head_ent  = dq_head;
  assign inst_pc   = XLEN'(head_ent.pc);
  assign inst_data = head_ent.inst;

  // FSM, PC and response bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC & ALIGN_MASK;
      outstanding <= '0;
      discard     <= '0;
      pend        <= 1'b0;
    end else begin
      case (state)
        S_BOOT:  state <= S_RUN;
        S_RUN:   if (!fetch_en) state <= S_HALT;
        S_HALT:  if (fetch_en) state <= S_RUN;
        default: state <= S_BOOT;
      endcase

      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ALIGN_MASK;
      end else if (gnt_fire) begin
        fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
      end

      outstanding <= outstanding + CW'(gnt_fire) - CW'(rv_fire);

      // Everything still owed after this cycle belongs to the abandoned stream.
      if (redirect_valid) begin
        discard <= outstanding - CW'(rv_fire);
      end else if (rv_fire && drop) begin
        discard <= discard - CW'(1);
      end

      // An ungranted request is held until granted or withdrawn by a redirect.
      pend <= mem_req && !mem_gnt;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_data_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (dq_push),
    .push_data  (push_ent),
    .pop        (dq_pop),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_data  (dq_head),
    .count      (count)
  );

  // PC tags for every owed response; dropped responses still consume their tag.
  fetch_queue #(
    .DEPTH (DEPTH),
    .W     (XLEN)
  ) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (gnt_fire),
    .push_data  (fetch_pc),
    .pop        (rv_fire),
    .flush      (1'b0),
    .head_valid (tag_valid),
    .head_data  (tag_pc),
    .count      (tag_count)
  );

  a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rvalid && (outstanding == '0)));

  a_tag_tracks : assert property (@(posedge clk) disable iff (!rst_n)
    (tag_count == outstanding) && (!rv_fire || tag_valid));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed table, corner sequences and a
// randomized run against a queue-based reference model with a latency memory.
module tb_fetch_ctrl;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  typedef struct {
    bit en; bit gnt; bit rdy;
    bit req; logic [31:0] addr; bit vld; logic [31:0] pc; logic [31:0] inst;
  } vec_t;

  mreq_t       mq[$];
  fl_t         infl[$];
  ent_t        iq[$];
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_pend;
  bit          e_req;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          grants = 0;
  int          tests = 0;
  int          fails = 0;
  vec_t        vt[7];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0100_0413;
      32'h4:   return 32'h1010_0493;
      32'h8:   return 32'h0084_8933;
      default: return {a[15:0], ~a[17:2]} ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: condition not reached within cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic drive_mem();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = mem_word(mq[0].addr);
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  // Called at a falling edge with inputs set: drives memory, then checks the model.
  task automatic pre();
    int credit;
    drive_mem();
    #1;
    credit = int'(DEPTH) - iq.size() - infl.size();
    e_req  = !redirect_valid && credit > 0 && (m_pend || (m_mode == 1 && fetch_en));
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("mem_addr", mem_addr, m_pc);
    chk("inst_valid", 32'(inst_valid), 32'(iq.size() > 0));
    if (iq.size() > 0) begin
      chk("inst_pc", inst_pc, iq[0].pc);
      chk("inst_data", inst_data, iq[0].inst);
    end
  endtask

  // Applies this cycle's events to memory and model, then advances one cycle.
  task automatic post();
    fl_t f;
    if (mem_rvalid && mq.size() > 0) mq.delete(0);
    if (mem_req && mem_gnt) begin
      mq.push_back('{addr: mem_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
      grants++;
    end
    if (iq.size() > 0 && inst_ready && !redirect_valid) iq.delete(0);
    if (mem_rvalid && infl.size() > 0) begin
      f = infl.pop_front();
      if (!f.stale && !redirect_valid) iq.push_back('{pc: f.pc, inst: mem_rdata});
    end
    if (redirect_valid) begin
      iq.delete();
      for (int i = 0; i < infl.size(); i++) infl[i].stale = 1'b1;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else if (e_req && mem_gnt) begin
      infl.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    m_pend = e_req && !mem_gnt;
    case (m_mode)
      0:       m_mode = 1;
      1:       if (!fetch_en) m_mode = 2;
      default: if (fetch_en) m_mode = 1;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step();
    pre();
    post();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fetch_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mq.delete(); iq.delete(); infl.delete();
    m_pc = RESET_PC; m_mode = 0; m_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [31:0] held;

    // en gnt rdy | req addr vld pc inst  (memory latency 1)
    vt[0] = '{1, 1, 1, 0, 32'h00, 0, 32'h0, 32'h0};
    vt[1] = '{1, 1, 1, 1, 32'h00, 0, 32'h0, 32'h0};
    vt[2] = '{1, 1, 1, 1, 32'h04, 0, 32'h0, 32'h0};
    vt[3] = '{1, 1, 1, 0, 32'h08, 1, 32'h0, 32'h0100_0413};
    vt[4] = '{1, 1, 1, 1, 32'h08, 1, 32'h4, 32'h1010_0493};
    vt[5] = '{1, 1, 1, 1, 32'h0C, 0, 32'h0, 32'h0};
    vt[6] = '{1, 1, 1, 0, 32'h10, 1, 32'h8, 32'h0084_8933};

    // Boot, first fetches and in-order delivery.
    lat_min = 1; lat_max = 1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      fetch_en = vt[i].en; mem_gnt = vt[i].gnt; inst_ready = vt[i].rdy;
      pre();
      chk("tbl_req", 32'(mem_req), 32'(vt[i].req));
      chk("tbl_addr", mem_addr, vt[i].addr);
      chk("tbl_valid", 32'(inst_valid), 32'(vt[i].vld));
      if (vt[i].vld) begin
        chk("tbl_pc", inst_pc, vt[i].pc);
        chk("tbl_inst", inst_data, vt[i].inst);
      end
      post();
    end

    // Decode stalled: exactly DEPTH grants, head held, then resume.
    do_reset();
    fetch_en = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b0;
    grants = 0;
    repeat (10) step();
    pre();
    chk("stall_req", 32'(mem_req), 32'h0);
    chk("stall_data", inst_data, 32'h0100_0413);
    chk("stall_grants", 32'(grants), 32'(DEPTH));
    post();
    inst_ready = 1'b1;
    repeat (12) step();

    // Redirect with two responses owed at latency 3.
    lat_min = 3; lat_max = 3;
    do_reset();
    fetch_en = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (infl.size() == 2) got = 1'b1;
    end
    if (!got) timeout("redir_two_outstanding");
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    pre();
    chk("redir_addr", mem_addr, 32'h0000_0100);
    post();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      pre();
      if (inst_valid) begin
        chk("redir_first_pc", inst_pc, 32'h0000_0100);
        got = 1'b1;
      end
      post();
    end
    if (!got) timeout("redir_first_delivery");

    // Grant withheld for 4 cycles, fetch_en dropped mid-wait.
    lat_min = 1; lat_max = 1;
    do_reset();
    fetch_en = 1'b1; mem_gnt = 1'b0; inst_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) fetch_en = 1'b0;
      pre();
      chk("wait_req", 32'(mem_req), 32'h1);
      chk("wait_addr", mem_addr, 32'h0);
      post();
    end
    mem_gnt = 1'b1;
    step();
    pre();
    chk("halt_req", 32'(mem_req), 32'h0);
    post();
    step();

    // Redirect while halted, then PC wrap past the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    pre();
    chk("halt_redir_req", 32'(mem_req), 32'h0);
    chk("halt_redir_addr", mem_addr, 32'hFFFF_FFFC);
    post();
    fetch_en = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      pre();
      if (mem_req) got = 1'b1;
      post();
    end
    if (!got) timeout("wrap_request");
    pre();
    chk("wrap_addr", mem_addr, 32'h0000_0000);
    post();
    repeat (6) step();

    // Reset asserted with a word buffered and a response still owed.
    lat_min = 4; lat_max = 4;
    do_reset();
    fetch_en = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      if (infl.size() == 1 && iq.size() == 1) got = 1'b1;
    end
    if (!got) timeout("midreset_setup");
    held = 32'(inst_valid);
    chk("midreset_pre_valid", held, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", 32'(inst_valid), 32'h0);
    chk("midreset_req", 32'(mem_req), 32'h0);
    do_reset();
    lat_min = 1; lat_max = 1;
    fetch_en = 1'b1; mem_gnt = 1'b1; inst_ready = 1'b1;
    pre();
    chk("boot_idle_req", 32'(mem_req), 32'h0);
    post();
    pre();
    chk("boot_first_req", 32'(mem_req), 32'h1);
    chk("boot_first_addr", mem_addr, RESET_PC);
    post();
    repeat (8) step();

    // Randomized traffic against the reference model.
    lat_min = 1; lat_max = 4;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      fetch_en       = ($urandom_range(0, 9) != 0);
      mem_gnt        = ($urandom_range(0, 3) != 0);
      inst_ready     = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 29) == 0);
      redirect_pc    = $urandom;
      step();
    end
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
